// File: rtl/led_pkg.sv
// led_mux_pwm shared definitions: output level codes, slot length
// helper, phase encoding and the row slice macro for flat frames.
`ifndef LED_PKG_SV
`define LED_PKG_SV

`define LED_ROW(vec, r, w) vec[(r)*(w) +: (w)]

package led_pkg;

  localparam bit LVL_ACTIVE_HIGH = 1'b0;
  localparam bit LVL_ACTIVE_LOW  = 1'b1;

  typedef enum logic {
    PH_BLANK  = 1'b0,
    PH_ACTIVE = 1'b1
  } phase_e;

  function automatic int slot_len(
    input int blank,
    input int prescale,
    input int pwm_bits
  );
    return blank + prescale * (1 << pwm_bits);
  endfunction

endpackage

`endif

// File: rtl/led_scan_timer.sv
// Row scan timing: blank/active phase FSM, prescaler, pwm counter, row.
// Ports: clk, rst_n; row_o, active_o, pwm_cnt_o, slot_first_o, commit_o.
module led_scan_timer
  import led_pkg::*;
#(
  parameter int NUM_ROWS       = 4,
  parameter int NUM_ROWS_WIDTH = 2,
  parameter int PWM_BITS       = 4,
  parameter int PWM_PRESCALE   = 16,
  parameter int PRESCALE_WIDTH = 4,
  parameter int BLANK_CYCLES   = 8,
  parameter int BLANK_WIDTH    = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [NUM_ROWS_WIDTH-1:0] row_o,
  output logic                      active_o,
  output logic [PWM_BITS-1:0]       pwm_cnt_o,
  output logic                      slot_first_o,
  output logic                      commit_o
);

  localparam logic [BLANK_WIDTH-1:0] BLANK_LAST =
    BLANK_WIDTH'(BLANK_CYCLES - 1);
  localparam logic [PRESCALE_WIDTH-1:0] PRE_LAST =
    PRESCALE_WIDTH'(PWM_PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] PWM_LAST = {PWM_BITS{1'b1}};
  localparam logic [NUM_ROWS_WIDTH-1:0] ROW_LAST =
    NUM_ROWS_WIDTH'(NUM_ROWS - 1);

  phase_e                    phase_q, phase_d;
  logic [BLANK_WIDTH-1:0]    blank_cnt_q, blank_cnt_d;
  logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic [NUM_ROWS_WIDTH-1:0] row_q, row_d;

  logic tick_end;
  logic slot_end;

  assign tick_end = (pre_cnt_q == PRE_LAST);
  assign slot_end = (phase_q == PH_ACTIVE) && tick_end &&
                    (pwm_cnt_q == PWM_LAST);

  always_comb begin
    phase_d     = phase_q;
    blank_cnt_d = blank_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    pwm_cnt_d   = pwm_cnt_q;
    row_d       = row_q;
    unique case (phase_q)
      PH_BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          blank_cnt_d = '0;
          phase_d     = PH_ACTIVE;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end
      PH_ACTIVE: begin
        if (tick_end) begin
          pre_cnt_d = '0;
          if (pwm_cnt_q == PWM_LAST) begin
            pwm_cnt_d = '0;
            phase_d   = PH_BLANK;
            row_d     = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
          end
        end else begin
          pre_cnt_d = pre_cnt_q + 1'b1;
        end
      end
      default: phase_d = PH_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= PH_BLANK;
      blank_cnt_q <= '0;
      pre_cnt_q   <= '0;
      pwm_cnt_q   <= '0;
      row_q       <= '0;
    end else begin
      phase_q     <= phase_d;
      blank_cnt_q <= blank_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      row_q       <= row_d;
    end
  end

  assign row_o        = row_q;
  assign active_o     = (phase_q == PH_ACTIVE);
  assign pwm_cnt_o    = pwm_cnt_q;
  assign slot_first_o = (phase_q == PH_BLANK) && (blank_cnt_q == '0);
  assign commit_o     = slot_end && (row_q == ROW_LAST);

endmodule

// File: rtl/led_mux_pwm.sv
// Row-multiplexed LED driver: double-buffered frame, PWM, blanking.
// Ports: clk, i_rst_n, i_enable, i_brightness, i_load, i_frame; o_pending, o_frame_start, o_cols, o_rows.
module led_mux_pwm
  import led_pkg::*;
#(
  parameter int NUM_ROWS              = 4,
  parameter int NUM_ROWS_WIDTH        = 2,
  parameter int NUM_COLS              = 8,
  parameter int PWM_BITS              = 4,
  parameter int PWM_PRESCALE          = 16,
  parameter int PRESCALE_WIDTH        = 4,
  parameter int BLANK_CYCLES          = 8,
  parameter int BLANK_WIDTH           = 3,
  parameter bit ROW_OUTPUT_ACTIVE_LOW = LVL_ACTIVE_HIGH,
  parameter bit COL_OUTPUT_ACTIVE_LOW = LVL_ACTIVE_HIGH
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic                         i_enable,
  input  logic [PWM_BITS-1:0]          i_brightness,
  input  logic                         i_load,
  input  logic [NUM_ROWS*NUM_COLS-1:0] i_frame,
  output logic                         o_pending,
  output logic                         o_frame_start,
  output logic [NUM_COLS-1:0]          o_cols,
  output logic [NUM_ROWS-1:0]          o_rows
);

  localparam int FRAME_BITS = NUM_ROWS * NUM_COLS;

  logic [NUM_ROWS_WIDTH-1:0] row;
  logic                      active;
  logic [PWM_BITS-1:0]       pwm_cnt;
  logic                      slot_first;
  logic                      commit;

  logic [FRAME_BITS-1:0] display_q, display_d;
  logic [FRAME_BITS-1:0] pend_buf_q, pend_buf_d;
  logic                  pending_q, pending_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic [NUM_COLS-1:0]   cols_q, cols_d;
  logic [NUM_ROWS-1:0]   rows_q, rows_d;
  logic                  frame_start_q, frame_start_d;
  logic [NUM_COLS-1:0]   row_bits;

  led_scan_timer #(
    .NUM_ROWS       (NUM_ROWS),
    .NUM_ROWS_WIDTH (NUM_ROWS_WIDTH),
    .PWM_BITS       (PWM_BITS),
    .PWM_PRESCALE   (PWM_PRESCALE),
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .BLANK_CYCLES   (BLANK_CYCLES),
    .BLANK_WIDTH    (BLANK_WIDTH)
  ) u_timer (
    .clk          (clk),
    .rst_n        (i_rst_n),
    .row_o        (row),
    .active_o     (active),
    .pwm_cnt_o    (pwm_cnt),
    .slot_first_o (slot_first),
    .commit_o     (commit)
  );

  assign row_bits = `LED_ROW(display_q, row, NUM_COLS);

  // A load on the commit cycle bypasses pending straight to display.
  always_comb begin
    pend_buf_d = pend_buf_q;
    pending_d  = pending_q;
    display_d  = display_q;
    if (i_load) pend_buf_d = i_frame;
    if (commit) begin
      pending_d = 1'b0;
      if (i_load) display_d = i_frame;
      else if (pending_q) display_d = pend_buf_q;
    end else if (i_load) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    duty_d        = slot_first ? i_brightness : duty_q;
    cols_d        = '0;
    rows_d        = '0;
    frame_start_d = slot_first && (row == '0);
    if (i_enable && active) begin
      rows_d = NUM_ROWS'(1) << row;
      if (pwm_cnt < duty_q) cols_d = row_bits;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      display_q     <= '0;
      pend_buf_q    <= '0;
      pending_q     <= 1'b0;
      duty_q        <= '0;
      cols_q        <= '0;
      rows_q        <= '0;
      frame_start_q <= 1'b0;
    end else begin
      display_q     <= display_d;
      pend_buf_q    <= pend_buf_d;
      pending_q     <= pending_d;
      duty_q        <= duty_d;
      cols_q        <= cols_d;
      rows_q        <= rows_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign o_pending     = pending_q;
  assign o_frame_start = frame_start_q;
  assign o_cols        = cols_q ^ {NUM_COLS{COL_OUTPUT_ACTIVE_LOW}};
  assign o_rows        = rows_q ^ {NUM_ROWS{ROW_OUTPUT_ACTIVE_LOW}};

endmodule

// File: tb/tb_led_mux_pwm.sv
// Bench for led_mux_pwm: position-based reference model, per-cycle
// compare of an active-high and an active-low instance, plus literals.
module tb_led_mux_pwm;

  localparam int NR    = 4;
  localparam int NC    = 8;
  localparam int PB    = 2;
  localparam int PS    = 1;
  localparam int BC    = 2;
  localparam int SLOT  = BC + PS * (1 << PB);
  localparam int FRAME = NR * SLOT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [PB-1:0] bri = '0;
  logic          ld = 1'b0;
  logic [31:0]   frm = '0;

  logic          o_pending, o_frame_start;
  logic [NC-1:0] o_cols;
  logic [NR-1:0] o_rows;
  logic          al_pending, al_frame_start;
  logic [NC-1:0] al_cols;
  logic [NR-1:0] al_rows;

  always #5 clk = ~clk;

  led_mux_pwm #(
    .NUM_ROWS(NR), .NUM_ROWS_WIDTH(2), .NUM_COLS(NC),
    .PWM_BITS(PB), .PWM_PRESCALE(PS), .PRESCALE_WIDTH(1),
    .BLANK_CYCLES(BC), .BLANK_WIDTH(1),
    .ROW_OUTPUT_ACTIVE_LOW(1'b0), .COL_OUTPUT_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .i_brightness(bri), .i_load(ld), .i_frame(frm),
    .o_pending(o_pending), .o_frame_start(o_frame_start),
    .o_cols(o_cols), .o_rows(o_rows)
  );

  led_mux_pwm #(
    .NUM_ROWS(NR), .NUM_ROWS_WIDTH(2), .NUM_COLS(NC),
    .PWM_BITS(PB), .PWM_PRESCALE(PS), .PRESCALE_WIDTH(1),
    .BLANK_CYCLES(BC), .BLANK_WIDTH(1),
    .ROW_OUTPUT_ACTIVE_LOW(1'b1), .COL_OUTPUT_ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .i_rst_n(rst_n), .i_enable(en),
    .i_brightness(bri), .i_load(ld), .i_frame(frm),
    .o_pending(al_pending), .o_frame_start(al_frame_start),
    .o_cols(al_cols), .o_rows(al_rows)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Model: pos = place of the internal scan within the frame (0..23).
  // Pins show, after each edge, what the position before it implied.
  int            pos = 0;
  logic [NC-1:0] mdisp [NR];
  logic [NC-1:0] mpbuf [NR];
  logic          mpend = 1'b0;
  int            mduty = 0;
  logic [NC-1:0] e_cols = '0;
  logic [NR-1:0] e_rows = '0;
  logic          e_fs = 1'b0;
  logic          e_pend = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pos = 0; mpend = 1'b0; mduty = 0;
        for (int i = 0; i < NR; i++) begin
          mdisp[i] = '0; mpbuf[i] = '0;
        end
        e_cols = '0; e_rows = '0; e_fs = 1'b0; e_pend = 1'b0;
      end else begin
        int r, s;
        r = pos / SLOT;
        s = pos % SLOT;
        if (s == 0) mduty = int'(bri);
        e_fs   = (pos == 0);
        e_rows = '0;
        e_cols = '0;
        if (en && s >= BC) begin
          e_rows = NR'(1 << r);
          if ((s - BC) / PS < mduty) e_cols = mdisp[r];
        end
        if (pos == FRAME - 1) begin
          if (ld) begin
            for (int i = 0; i < NR; i++) mdisp[i] = frm[i*NC +: NC];
          end else if (mpend) begin
            for (int i = 0; i < NR; i++) mdisp[i] = mpbuf[i];
          end
          mpend = 1'b0;
        end else if (ld) begin
          for (int i = 0; i < NR; i++) mpbuf[i] = frm[i*NC +: NC];
          mpend = 1'b1;
        end
        e_pend = mpend;
        pos = (pos + 1) % FRAME;
      end
    end
  end

  initial begin
    logic [NC-1:0] inv_c;
    logic [NR-1:0] inv_r;
    forever begin
      @(negedge clk);
      inv_c = ~e_cols;
      inv_r = ~e_rows;
      chk("cols", o_cols, e_cols);
      chk("rows", o_rows, e_rows);
      chk("frame_start", o_frame_start, e_fs);
      chk("pending", o_pending, e_pend);
      chk("al_cols", al_cols, inv_c);
      chk("al_rows", al_rows, inv_r);
      chk("al_frame_start", al_frame_start, e_fs);
      chk("al_pending", al_pending, e_pend);
    end
  end

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    @(negedge clk);
    while (pos != p && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (pos != p) chk("wait_pos", pos, p);
  endtask

  initial begin
    int n_a, n_b, n_act, n_col, per;
    logic got;

    // Reset state
    nclk(3);
    chk("rst_cols", o_cols, 8'h00);
    chk("rst_rows", o_rows, 4'h0);
    chk("rst_pend", o_pending, 1'b0);
    chk("rst_fs", o_frame_start, 1'b0);
    chk("rst_al_cols", al_cols, 8'hFF);
    chk("rst_al_rows", al_rows, 4'hF);

    // Release, load mid-frame
    rst_n = 1'b1; en = 1'b1; bri = 2'd3;
    nclk(1);
    chk("first_fs", o_frame_start, 1'b1);
    nclk(8);
    ld = 1'b1; frm = 32'h1824_4281;
    nclk(1);
    ld = 1'b0;
    chk("pend_set", o_pending, 1'b1);
    wait_pos(FRAME - 1);
    chk("pend_hold", o_pending, 1'b1);
    nclk(1);
    chk("pend_clr", o_pending, 1'b0);
    n_a = 0; n_b = 0; n_act = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (o_cols == 8'h81 && o_rows == 4'b0001) n_a++;
      if (o_cols == 8'h42 && o_rows == 4'b0010) n_b++;
      if (o_rows != 0) n_act++;
    end
    chk("row0_81", n_a, 3);
    chk("row1_42", n_b, 3);
    chk("rows_active", n_act, 16);

    // Brightness 0 then 1
    bri = 2'd0;
    nclk(30);
    n_col = 0; n_act = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (o_cols != 0) n_col++;
      if (o_rows != 0) n_act++;
    end
    chk("bri0_cols", n_col, 0);
    chk("bri0_rows", n_act, 16);
    bri = 2'd1;
    nclk(30);
    n_col = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (o_cols != 0) n_col++;
    end
    chk("bri1_cols", n_col, 4);

    // Two loads in one frame: latest wins
    bri = 2'd3;
    wait_pos(2);
    ld = 1'b1; frm = 32'hFFFF_FFFF;
    nclk(1);
    ld = 1'b0;
    nclk(3);
    ld = 1'b1; frm = 32'h0F0F_0F0F;
    nclk(1);
    ld = 1'b0;
    wait_pos(0);
    n_a = 0; n_b = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (o_cols == 8'hFF) n_a++;
      if (o_cols == 8'h0F) n_b++;
    end
    chk("dbl_ff", n_a, 0);
    chk("dbl_0f", n_b, 12);

    // Load exactly on the commit cycle
    wait_pos(FRAME - 1);
    ld = 1'b1; frm = 32'h1122_3344;
    nclk(1);
    ld = 1'b0;
    chk("bypass_pend", o_pending, 1'b0);
    n_a = 0; n_b = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (o_cols == 8'h44 && o_rows == 4'b0001) n_a++;
      if (o_cols == 8'h11 && o_rows == 4'b1000) n_b++;
    end
    chk("bypass_r0", n_a, 3);
    chk("bypass_r3", n_b, 3);

    // Enable low for 10 clocks: scan period unchanged
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (o_frame_start) got = 1'b1;
    end
    chk("fs_seen", got, 1'b1);
    en = 1'b0; got = 1'b0; per = 0; n_act = 0;
    for (int k = 1; k <= 50 && !got; k++) begin
      @(negedge clk);
      if (k <= 10 && o_rows != 0) n_act++;
      if (k == 5) begin
        chk("dis_al_rows", al_rows, 4'hF);
        chk("dis_al_cols", al_cols, 8'hFF);
      end
      if (k == 10) en = 1'b1;
      if (o_frame_start) begin
        got = 1'b1; per = k;
      end
    end
    chk("fs_period", per, FRAME);
    chk("dis_rows", n_act, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ld  = ($urandom_range(0, 7) == 0);
      frm = $urandom;
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) bri = PB'($urandom_range(0, 3));
    end
    @(negedge clk);
    ld = 1'b0; en = 1'b1; bri = 2'd3;

    // Reset while row 2 is active
    wait_pos(2 * SLOT + BC + 2);
    chk("pre_rst_row2", o_rows, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rows", o_rows, 4'h0);
    chk("async_cols", o_cols, 8'h00);
    chk("async_al_rows", al_rows, 4'hF);
    chk("async_pend", o_pending, 1'b0);
    nclk(3);
    rst_n = 1'b1;
    nclk(1);
    chk("rst2_fs", o_frame_start, 1'b1);
    n_col = 0; n_act = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (o_cols != 0) n_col++;
      if (o_rows != 0) n_act++;
    end
    chk("rst2_dark", n_col, 0);
    chk("rst2_rows", n_act, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
